// File: rtl/axi_lite_resp_pkg.sv
// Shared widths and FSM encodings for the AXI4-Lite register responder.
package axi_lite_resp_pkg;

  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    WS_IDLE = 2'd0,
    WS_LAT  = 2'd1,
    WS_RESP = 2'd2
  } wr_state_e;

  typedef enum logic [1:0] {
    RS_IDLE = 2'd0,
    RS_LAT  = 2'd1,
    RS_DATA = 2'd2
  } rd_state_e;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO; head shows the oldest entry while not empty.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo_fwft #(
  parameter int WIDTH = 39,
  parameter int DEPTH = 16
) (
  input  logic             i_sys_clk,
  input  logic             i_arstn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Extra pointer MSB tells full from empty when the index bits match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign head    = mem[rd_ptr[PTR_W-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_sys_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge i_sys_clk) begin
    if (push_ok) mem[wr_ptr[PTR_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/axi_lite_reg_responder.sv
// AXI4-Lite responder over a 32-word register file with programmable response latency
// and a FIFO log of every committed write.
module axi_lite_reg_responder
  import axi_lite_resp_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int B_LAT     = 2,
  parameter int R_LAT     = 1,
  parameter int LOG_DEPTH = 16
) (
  input  logic              i_sys_clk,
  input  logic              i_arstn,
  input  logic [ADDR_W-1:0] i_axi_awaddr,
  input  logic              i_axi_awvalid,
  output logic              o_axi_awready,
  input  logic [DATA_W-1:0] i_axi_wdata,
  input  logic              i_axi_wvalid,
  output logic              o_axi_wready,
  output logic              o_axi_bvalid,
  input  logic              i_axi_bready,
  input  logic [ADDR_W-1:0] i_axi_araddr,
  input  logic              i_axi_arvalid,
  output logic              o_axi_arready,
  output logic [DATA_W-1:0] o_axi_rdata,
  output logic              o_axi_rvalid,
  input  logic              i_axi_rready,
  output logic [ADDR_W-1:0] o_log_addr,
  output logic [DATA_W-1:0] o_log_data,
  output logic              o_log_valid,
  input  logic              i_log_ready,
  output logic              o_log_overflow,
  output logic [15:0]       o_wr_count
);

  localparam int IDX_W  = ADDR_W - 2;
  localparam int NWORDS = 1 << IDX_W;
  localparam int LOG_W  = ADDR_W + DATA_W;

  wr_state_e         ws, ws_nxt;
  rd_state_e         rs, rs_nxt;
  logic              live;
  logic              aw_held, w_held;
  logic [ADDR_W-1:0] aw_addr;
  logic [DATA_W-1:0] w_data;
  logic [CNT_W-1:0]  wcnt, rcnt;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] regs [NWORDS];

  logic              aw_hs, w_hs, ar_hs, commit, r_sample;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_data;
  logic [IDX_W-1:0]  sample_idx;
  logic              log_full, log_empty, log_pop;
  logic [LOG_W-1:0]  log_head;
  logic              unused_ar_lsb;

  // `live` holds every ready low while reset is asserted and for the first cycle after.
  assign o_axi_awready = live & (ws == WS_IDLE) & ~aw_held;
  assign o_axi_wready  = live & (ws == WS_IDLE) & ~w_held;
  assign o_axi_bvalid  = (ws == WS_RESP);
  assign o_axi_arready = live & (rs == RS_IDLE);
  assign o_axi_rvalid  = (rs == RS_DATA);

  assign aw_hs  = i_axi_awvalid & o_axi_awready;
  assign w_hs   = i_axi_wvalid & o_axi_wready;
  assign ar_hs  = i_axi_arvalid & o_axi_arready;
  // An address or data beat accepted this cycle counts as held, so commit needs no extra cycle.
  assign commit = (aw_held | aw_hs) & (w_held | w_hs);
  assign c_addr = aw_held ? aw_addr : i_axi_awaddr;
  assign c_data = w_held ? w_data : i_axi_wdata;

  always_ff @(posedge i_sys_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      ws   <= WS_IDLE;
      rs   <= RS_IDLE;
      live <= 1'b0;
    end else begin
      ws   <= ws_nxt;
      rs   <= rs_nxt;
      live <= 1'b1;
    end
  end

  // NOTE: next state is defaulted first so no path through the case can infer a latch.
  always_comb begin
    ws_nxt = ws;
    case (ws)
      WS_IDLE: if (commit) ws_nxt = (B_LAT == 0) ? WS_RESP : WS_LAT;
      WS_LAT:  if (wcnt == CNT_W'(1)) ws_nxt = WS_RESP;
      WS_RESP: if (i_axi_bready) ws_nxt = WS_IDLE;
      default: ws_nxt = WS_IDLE;
    endcase
  end

  always_comb begin
    rs_nxt = rs;
    case (rs)
      RS_IDLE: if (ar_hs) rs_nxt = (R_LAT == 0) ? RS_DATA : RS_LAT;
      RS_LAT:  if (rcnt == CNT_W'(1)) rs_nxt = RS_DATA;
      RS_DATA: if (i_axi_rready) rs_nxt = RS_IDLE;
      default: rs_nxt = RS_IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      aw_held    <= 1'b0;
      w_held     <= 1'b0;
      aw_addr    <= '0;
      w_data     <= '0;
      wcnt       <= '0;
      o_wr_count <= '0;
    end else if (commit) begin
      aw_held    <= 1'b0;
      w_held     <= 1'b0;
      wcnt       <= CNT_W'(B_LAT);
      o_wr_count <= o_wr_count + 16'd1;
    end else begin
      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_addr <= i_axi_awaddr;
      end
      if (w_hs) begin
        w_held <= 1'b1;
        w_data <= i_axi_wdata;
      end
      if (ws == WS_LAT) wcnt <= wcnt - CNT_W'(1);
    end
  end

  // Register file comes out of reset all-zero; a commit writes the whole word.
  always_ff @(posedge i_sys_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      for (int i = 0; i < NWORDS; i++) regs[i] <= '0;
    end else if (commit) begin
      regs[c_addr[ADDR_W-1:2]] <= c_data;
    end
  end

  // rdata is captured on the edge entering RS_DATA; a same-edge commit is not forwarded.
  assign r_sample      = (rs != RS_DATA) && (rs_nxt == RS_DATA);
  assign sample_idx    = (rs == RS_IDLE) ? i_axi_araddr[ADDR_W-1:2] : r_idx;
  assign unused_ar_lsb = ^i_axi_araddr[1:0];

  always_ff @(posedge i_sys_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      r_idx       <= '0;
      rcnt        <= '0;
      o_axi_rdata <= '0;
    end else begin
      if (ar_hs) begin
        r_idx <= i_axi_araddr[ADDR_W-1:2];
        rcnt  <= CNT_W'(R_LAT);
      end else if (rs == RS_LAT) begin
        rcnt <= rcnt - CNT_W'(1);
      end
      if (r_sample) o_axi_rdata <= regs[sample_idx];
    end
  end

  assign log_pop = o_log_valid & i_log_ready;

  sync_fifo_fwft #(
    .WIDTH (LOG_W),
    .DEPTH (LOG_DEPTH)
  ) u_log_fifo (
    .i_sys_clk (i_sys_clk),
    .i_arstn   (i_arstn),
    .push      (commit),
    .push_data ({c_addr, c_data}),
    .pop       (log_pop),
    .head      (log_head),
    .full      (log_full),
    .empty     (log_empty)
  );

  assign o_log_valid = ~log_empty;
  assign {o_log_addr, o_log_data} = log_empty ? '0 : log_head;

  always_ff @(posedge i_sys_clk or negedge i_arstn) begin
    if (!i_arstn)                          o_log_overflow <= 1'b0;
    else if (commit & log_full & ~log_pop) o_log_overflow <= 1'b1;
  end

endmodule

// File: tb/tb_axi_lite_reg_responder.sv
// Self-checking bench: vector table, directed latency/corner sequences, and random traffic
// checked against an array/queue reference model.
module tb_axi_lite_reg_responder;

  logic        i_sys_clk = 1'b0;
  logic        i_arstn   = 1'b1;
  logic [6:0]  i_axi_awaddr = '0;
  logic        i_axi_awvalid = 1'b0;
  logic        o_axi_awready;
  logic [31:0] i_axi_wdata = '0;
  logic        i_axi_wvalid = 1'b0;
  logic        o_axi_wready;
  logic        o_axi_bvalid;
  logic        i_axi_bready = 1'b1;
  logic [6:0]  i_axi_araddr = '0;
  logic        i_axi_arvalid = 1'b0;
  logic        o_axi_arready;
  logic [31:0] o_axi_rdata;
  logic        o_axi_rvalid;
  logic        i_axi_rready = 1'b0;
  logic [6:0]  o_log_addr;
  logic [31:0] o_log_data;
  logic        o_log_valid;
  logic        i_log_ready = 1'b0;
  logic        o_log_overflow;
  logic [15:0] o_wr_count;

  always #5 i_sys_clk = ~i_sys_clk;

  axi_lite_reg_responder #(
    .ADDR_W(7), .DATA_W(32), .B_LAT(2), .R_LAT(1), .LOG_DEPTH(16)
  ) dut (
    .i_sys_clk      (i_sys_clk),
    .i_arstn        (i_arstn),
    .i_axi_awaddr   (i_axi_awaddr),
    .i_axi_awvalid  (i_axi_awvalid),
    .o_axi_awready  (o_axi_awready),
    .i_axi_wdata    (i_axi_wdata),
    .i_axi_wvalid   (i_axi_wvalid),
    .o_axi_wready   (o_axi_wready),
    .o_axi_bvalid   (o_axi_bvalid),
    .i_axi_bready   (i_axi_bready),
    .i_axi_araddr   (i_axi_araddr),
    .i_axi_arvalid  (i_axi_arvalid),
    .o_axi_arready  (o_axi_arready),
    .o_axi_rdata    (o_axi_rdata),
    .o_axi_rvalid   (o_axi_rvalid),
    .i_axi_rready   (i_axi_rready),
    .o_log_addr     (o_log_addr),
    .o_log_data     (o_log_data),
    .o_log_valid    (o_log_valid),
    .i_log_ready    (i_log_ready),
    .o_log_overflow (o_log_overflow),
    .o_wr_count     (o_wr_count)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: word array, log queue, write counter, sticky overflow.
  logic [31:0] mem_m [32];
  logic [38:0] log_q [$];
  int          wr_cnt_m = 0;
  bit          ovf_m    = 1'b0;

  typedef struct {
    logic [6:0]  wa;
    logic [31:0] wd;
    logic [6:0]  ra;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t        vecs [6];
  logic [31:0] rdv;
  logic [31:0] held_rd;
  logic [6:0]  ra;
  logic [31:0] rnd_d;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge i_sys_clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mem_m[i] = '0;
    log_q.delete();
    wr_cnt_m = 0;
    ovf_m    = 1'b0;
  endtask

  task automatic model_write(input logic [6:0] a, input logic [31:0] d, input bit pop);
    mem_m[a[6:2]] = d;
    wr_cnt_m = (wr_cnt_m + 1) % 65536;
    if (pop && log_q.size() > 0) void'(log_q.pop_front());
    if (log_q.size() < 16) log_q.push_back({a, d});
    else ovf_m = 1'b1;
  endtask

  task automatic wait_b();
    int n = 0;
    i_axi_bready = 1'b1;
    while (!o_axi_bvalid && n < 40) begin step(); n++; end
    check("b_seen", o_axi_bvalid, 1);
    step();
  endtask

  // AW and W offered together; each valid drops once its own beat is accepted.
  task automatic do_write(input logic [6:0] a, input logic [31:0] d, input bit pop);
    bit aw_done = 0, w_done = 0;
    int n = 0;
    i_axi_awaddr = a; i_axi_wdata = d;
    i_axi_awvalid = 1'b1; i_axi_wvalid = 1'b1;
    i_log_ready = pop;
    while (!(aw_done && w_done) && n < 20) begin
      if (o_axi_awready) aw_done = 1;
      if (o_axi_wready)  w_done  = 1;
      step(); n++;
      i_log_ready = 1'b0;
      if (aw_done) i_axi_awvalid = 1'b0;
      if (w_done)  i_axi_wvalid  = 1'b0;
    end
    i_axi_awvalid = 1'b0; i_axi_wvalid = 1'b0;
    check("wr_accept", {31'd0, aw_done && w_done}, 1);
    model_write(a, d, pop);
    wait_b();
  endtask

  task automatic do_read(input logic [6:0] a, output logic [31:0] d, input int rdly);
    int n = 0;
    logic [31:0] first;
    i_axi_araddr = a; i_axi_arvalid = 1'b1; i_axi_rready = 1'b0;
    while (!o_axi_arready && n < 20) begin step(); n++; end
    check("ar_accept", o_axi_arready, 1);
    step();
    i_axi_arvalid = 1'b0;
    n = 0;
    while (!o_axi_rvalid && n < 40) begin step(); n++; end
    check("r_seen", o_axi_rvalid, 1);
    first = o_axi_rdata;
    for (int k = 0; k < rdly; k++) begin
      step();
      check("rdata_hold", {o_axi_rvalid, o_axi_rdata}, {1'b1, first});
    end
    i_axi_rready = 1'b1;
    step();
    i_axi_rready = 1'b0;
    d = first;
  endtask

  task automatic drain_log();
    int n = 0;
    while (log_q.size() > 0 && n < 40) begin
      check("log_head", {o_log_valid, o_log_addr, o_log_data}, {1'b1, log_q[0]});
      i_log_ready = 1'b1;
      step();
      i_log_ready = 1'b0;
      void'(log_q.pop_front());
      n++;
    end
    check("log_empty", o_log_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1);
  end

  initial begin
    vecs[0] = '{wa: 7'h08, wd: 32'hA5A5_A5A5, ra: 7'h0B, exp_rd: 32'hA5A5_A5A5};
    vecs[1] = '{wa: 7'h7C, wd: 32'h0000_0001, ra: 7'h7F, exp_rd: 32'h0000_0001};
    vecs[2] = '{wa: 7'h7F, wd: 32'hCAFE_F00D, ra: 7'h7C, exp_rd: 32'hCAFE_F00D};
    vecs[3] = '{wa: 7'h00, wd: 32'hFFFF_FFFF, ra: 7'h00, exp_rd: 32'hFFFF_FFFF};
    vecs[4] = '{wa: 7'h01, wd: 32'h0000_0000, ra: 7'h02, exp_rd: 32'h0000_0000};
    vecs[5] = '{wa: 7'h40, wd: 32'h1357_9BDF, ra: 7'h08, exp_rd: 32'hA5A5_A5A5};
    model_reset();

    // Reset state
    #2 i_arstn = 1'b0;
    step(); step();
    check("rst_readies", {o_axi_awready, o_axi_wready, o_axi_arready}, 0);
    check("rst_valids", {o_axi_bvalid, o_axi_rvalid, o_log_valid}, 0);
    check("rst_rdata", o_axi_rdata, 0);
    check("rst_log_data", {o_log_addr, o_log_data}, 0);
    check("rst_ovf_cnt", {o_log_overflow, o_wr_count}, 0);
    i_arstn = 1'b1;
    step(); step();
    check("post_rst_readies", {o_axi_awready, o_axi_wready, o_axi_arready}, 3'b111);

    // AW and W in the same cycle, bvalid exactly 3 cycles after the handshake
    i_axi_awaddr = 7'h04; i_axi_wdata = 32'hDEAD_BEEF;
    i_axi_awvalid = 1'b1; i_axi_wvalid = 1'b1; i_axi_bready = 1'b1;
    check("t1_ready", {o_axi_awready, o_axi_wready}, 2'b11);
    step();
    i_axi_awvalid = 1'b0; i_axi_wvalid = 1'b0;
    model_write(7'h04, 32'hDEAD_BEEF, 0);
    check("t1_b_h1", o_axi_bvalid, 0);
    step();
    check("t1_b_h2", o_axi_bvalid, 0);
    step();
    check("t1_b_h3", o_axi_bvalid, 1);
    step();
    check("t1_log_head", {o_log_valid, o_log_addr, o_log_data}, {1'b1, 7'h04, 32'hDEAD_BEEF});
    check("t1_wr_count", o_wr_count, 1);

    // W two cycles ahead of AW, bready held low while a second AW waits
    i_axi_bready = 1'b0;
    i_axi_wdata = 32'h1234_5678; i_axi_wvalid = 1'b1;
    check("t2_w_ready", o_axi_wready, 1);
    step();
    i_axi_wvalid = 1'b0;
    check("t2_wready_drop", {o_axi_wready, o_axi_awready}, 2'b01);
    step();
    i_axi_awaddr = 7'h10; i_axi_awvalid = 1'b1;
    check("t2_aw_ready", o_axi_awready, 1);
    step();
    i_axi_awvalid = 1'b0;
    model_write(7'h10, 32'h1234_5678, 0);
    for (int n = 0; n < 20 && !o_axi_bvalid; n++) step();
    for (int k = 0; k < 5; k++) begin
      i_axi_awaddr = 7'h14; i_axi_awvalid = 1'b1;
      check("t2_b_hold", {o_axi_bvalid, o_axi_awready}, 2'b10);
      step();
    end
    i_axi_bready = 1'b1;
    step();
    check("t2_aw_in_idle", o_axi_awready, 1);
    i_axi_wdata = 32'h9ABC_DEF0; i_axi_wvalid = 1'b1;
    step();
    i_axi_awvalid = 1'b0; i_axi_wvalid = 1'b0;
    model_write(7'h14, 32'h9ABC_DEF0, 0);
    wait_b();

    // Read latency and rdata stability while rready is withheld
    do_write(7'h08, 32'hA5A5_A5A5, 0);
    i_axi_araddr = 7'h08; i_axi_arvalid = 1'b1;
    check("t3_ar_ready", o_axi_arready, 1);
    step();
    i_axi_arvalid = 1'b0;
    check("t3_r_early", o_axi_rvalid, 0);
    step();
    check("t3_r_lat", {o_axi_rvalid, o_axi_rdata}, {1'b1, 32'hA5A5_A5A5});
    for (int k = 0; k < 3; k++) begin
      step();
      check("t3_r_stable", {o_axi_rvalid, o_axi_rdata}, {1'b1, 32'hA5A5_A5A5});
    end
    i_axi_rready = 1'b1;
    step();
    i_axi_rready = 1'b0;
    check("t3_r_done", o_axi_rvalid, 0);
    do_read(7'h0B, rdv, 1);
    check("t3_alias", rdv, 32'hA5A5_A5A5);

    // Vector table
    for (int i = 0; i < 6; i++) begin
      do_write(vecs[i].wa, vecs[i].wd, 0);
      do_read(vecs[i].ra, rdv, i % 3);
      check("vec_read", rdv, vecs[i].exp_rd);
    end

    // Read sample coinciding with a commit to the same word returns the old value
    do_write(7'h0C, 32'h11, 0);
    i_axi_araddr = 7'h0C; i_axi_arvalid = 1'b1;
    step();
    i_axi_arvalid = 1'b0;
    i_axi_awaddr = 7'h0C; i_axi_wdata = 32'h55;
    i_axi_awvalid = 1'b1; i_axi_wvalid = 1'b1; i_axi_bready = 1'b1;
    check("t5_ready", {o_axi_awready, o_axi_wready}, 2'b11);
    step();
    i_axi_awvalid = 1'b0; i_axi_wvalid = 1'b0;
    model_write(7'h0C, 32'h55, 0);
    check("t5_collision_old", {o_axi_rvalid, o_axi_rdata}, {1'b1, 32'h11});
    i_axi_rready = 1'b1;
    step();
    i_axi_rready = 1'b0;
    wait_b();
    do_read(7'h0C, rdv, 0);
    check("t5_new", rdv, 32'h55);

    // 17 writes with no log pops: 16 logged, 17th dropped but still committed
    drain_log();
    for (int i = 0; i < 17; i++) begin
      do_write(7'(4 * i), 32'h1000_0000 + 32'(i), 0);
      if (i == 15) check("t4_no_ovf_at_16", o_log_overflow, 0);
    end
    check("t4_ovf", o_log_overflow, 1);
    check("t4_wr_count", o_wr_count, 16'(wr_cnt_m));
    do_read(7'h40, rdv, 0);
    check("t4_17th_reg", rdv, 32'h1000_0010);
    check("t4_log_len", 32'(log_q.size()), 16);
    drain_log();

    // Random traffic against the model
    for (int i = 0; i < 80; i++) begin
      ra    = 7'($urandom_range(0, 127));
      rnd_d = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        do_write(ra, rnd_d, 0);
      end else begin
        do_read(ra, rdv, $urandom_range(0, 3));
        check("rand_read", rdv, mem_m[ra[6:2]]);
      end
    end
    check("rand_wr_count", o_wr_count, 16'(wr_cnt_m));
    check("rand_ovf", o_log_overflow, ovf_m);
    drain_log();

    // Reset while the write path is in WS_LAT and the read path in RS_DATA
    i_axi_araddr = 7'h08; i_axi_arvalid = 1'b1;
    step();
    i_axi_arvalid = 1'b0;
    step();
    check("t6_r_pending", o_axi_rvalid, 1);
    i_axi_awaddr = 7'h20; i_axi_wdata = 32'h7777_7777;
    i_axi_awvalid = 1'b1; i_axi_wvalid = 1'b1;
    step();
    i_axi_awvalid = 1'b0; i_axi_wvalid = 1'b0;
    check("t6_in_lat", o_axi_bvalid, 0);
    #2 i_arstn = 1'b0;
    #1;
    check("t6_rst_valids", {o_axi_bvalid, o_axi_rvalid}, 0);
    check("t6_rst_state", {o_log_valid, o_log_overflow, o_wr_count, o_axi_rdata}, 0);
    model_reset();
    step(); step();
    i_arstn = 1'b1;
    i_axi_bready = 1'b1; i_axi_rready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      check("t6_no_resp", {o_axi_bvalid, o_axi_rvalid}, 0);
    end
    i_axi_rready = 1'b0;
    do_read(7'h08, rdv, 0);
    check("t6_reg08_clr", rdv, mem_m[2]);
    do_read(7'h20, rdv, 0);
    check("t6_reg20_clr", rdv, mem_m[8]);
    check("t6_wr_count", o_wr_count, 0);

    // Push and pop together on a full log: no overflow
    for (int i = 0; i < 16; i++) do_write(7'(4 * i + 1), 32'hB000_0000 + 32'(i), 0);
    check("ff_full_no_ovf", o_log_overflow, 0);
    do_write(7'h7C, 32'hF00D_F00D, 1);
    check("ff_pushpop_no_ovf", o_log_overflow, ovf_m);
    check("ff_wr_count", o_wr_count, 16'(wr_cnt_m));
    drain_log();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
